// File: rtl/sensor_threshold_finder_pkg.sv
// Shared widths, constants and the state encoding for the sensor threshold finder.
// Model: temperature = base + ((sensor * coef) >> SHIFT).
package sensor_threshold_finder_pkg;

   localparam int SENSOR_W = 4;
   localparam int SHIFT    = 3;
   localparam int BASE_W   = 5;
   localparam int COEF_W   = 4;
   localparam int TEMP_W   = 8;

   localparam logic [SENSOR_W-1:0] SENSOR_MAX = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

endpackage

// File: rtl/sensor_threshold_finder_temp_model.sv
// Combinational forward temperature model: base + ((s * coef) >> SHIFT).
// The 8-bit product and the 8-bit sum cannot overflow for 5/4/4-bit operands.
module temp_model
   import sensor_threshold_finder_pkg::*;
(
   input  logic [BASE_W-1:0]   base_i,
   input  logic [COEF_W-1:0]   coef_i,
   input  logic [SENSOR_W-1:0] s_i,
   output logic [TEMP_W-1:0]   temp_o
);

   logic [TEMP_W-1:0] product;
   logic [TEMP_W-1:0] scaled;

   assign product = {4'b0000, s_i} * {4'b0000, coef_i};
   assign scaled  = product >> SHIFT;
   assign temp_o  = {3'b000, base_i} + scaled;

endmodule

// File: rtl/sensor_threshold_finder.sv
// Inverts the forward temperature model: walks s = 0..15 one per cycle and reports
// the smallest s whose modelled temperature reaches the latched target.
module sensor_threshold_finder
   import sensor_threshold_finder_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [BASE_W-1:0]   factory_base_temp,
   input  logic [COEF_W-1:0]   factory_temp_coef,
   input  logic [TEMP_W-1:0]   target_temp,
   output logic                busy,
   output logic                done,
   output logic                found,
   output logic [SENSOR_W-1:0] sensor_threshold,
   output logic [TEMP_W-1:0]   model_temp
);

   state_e              state_q, state_d;
   logic [SENSOR_W-1:0] s_q, s_d;
   logic [BASE_W-1:0]   base_q, base_d;
   logic [COEF_W-1:0]   coef_q, coef_d;
   logic [TEMP_W-1:0]   target_q, target_d;
   logic                found_q, found_d;
   logic [SENSOR_W-1:0] thr_q, thr_d;
   logic [TEMP_W-1:0]   model_q, model_d;
   logic [TEMP_W-1:0]   model_s;

   temp_model u_temp_model (
      .base_i (base_q),
      .coef_i (coef_q),
      .s_i    (s_q),
      .temp_o (model_s)
   );

   // NOTE: every next-state variable takes its held value first, so no path leaves it unassigned (no latch).
   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      base_d   = base_q;
      coef_d   = coef_q;
      target_d = target_q;
      found_d  = found_q;
      thr_d    = thr_q;
      model_d  = model_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               base_d   = factory_base_temp;
               coef_d   = factory_temp_coef;
               target_d = target_temp;
               s_d      = '0;
               state_d  = ST_SEARCH;
            end
         end
         ST_SEARCH: begin
            if (model_s >= target_q) begin
               thr_d   = s_q;
               model_d = model_s;
               found_d = 1'b1;
               state_d = ST_DONE;
            end else if (s_q == SENSOR_MAX) begin
               thr_d   = SENSOR_MAX;
               model_d = model_s;
               found_d = 1'b0;
               state_d = ST_DONE;
            end else begin
               s_d = s_q + 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         s_q      <= '0;
         base_q   <= '0;
         coef_q   <= '0;
         target_q <= '0;
         found_q  <= 1'b0;
         thr_q    <= '0;
         model_q  <= '0;
      end else begin
         state_q  <= state_d;
         s_q      <= s_d;
         base_q   <= base_d;
         coef_q   <= coef_d;
         target_q <= target_d;
         found_q  <= found_d;
         thr_q    <= thr_d;
         model_q  <= model_d;
      end
   end

   // Results stay registered across later searches; only reset clears them.
   assign busy             = (state_q == ST_SEARCH);
   assign done             = (state_q == ST_DONE);
   assign found            = found_q;
   assign sensor_threshold = thr_q;
   assign model_temp       = model_q;

endmodule

// File: tb/tb_sensor_threshold_finder.sv
// Scoreboard bench: the driver queues the expected result of each accepted start,
// a negedge monitor pops and compares on every done pulse.
module tb_sensor_threshold_finder;
   import sensor_threshold_finder_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [4:0]  base = '0;
   logic [3:0]  coef = '0;
   logic [7:0]  target = '0;
   logic        busy, done, found;
   logic [3:0]  sensor_threshold;
   logic [7:0]  model_temp;

   sensor_threshold_finder dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .factory_base_temp (base),
      .factory_temp_coef (coef),
      .target_temp       (target),
      .busy              (busy),
      .done              (done),
      .found             (found),
      .sensor_threshold  (sensor_threshold),
      .model_temp        (model_temp)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       found;
      logic [3:0] thr;
      logic [7:0] model;
      int         edges;
      int         busy_cycles;
      int         start_cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Independent reference: linear search over base + floor(s*coef/8).
   function automatic exp_t golden(input logic [4:0] b, input logic [3:0] c, input logic [7:0] t);
      exp_t e;
      int   m;
      e.found = 1'b0;
      e.thr   = 4'd15;
      e.model = 8'(int'(b) + (15 * int'(c)) / 8);
      for (int s = 0; s < 16; s++) begin
         m = int'(b) + (s * int'(c)) / 8;
         if (m >= int'(t)) begin
            e.found = 1'b1;
            e.thr   = 4'(s);
            e.model = 8'(m);
            break;
         end
      end
      e.edges       = 0;
      e.busy_cycles = 0;
      e.start_cyc   = 0;
      return e;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor
   initial begin
      int         busy_cnt;
      logic       last_found;
      logic [3:0] last_thr;
      logic [7:0] last_model;
      exp_t       e;
      busy_cnt   = 0;
      last_found = 1'b0;
      last_thr   = '0;
      last_model = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy_cnt   = 0;
            last_found = 1'b0;
            last_thr   = '0;
            last_model = '0;
         end else begin
            if (busy) begin
               if (busy_cnt == 0) begin
                  check("hold_found", found, last_found);
                  check("hold_threshold", sensor_threshold, last_thr);
                  check("hold_model", model_temp, last_model);
               end
               busy_cnt++;
            end
            if (done) begin
               check("busy_low_in_done", busy, 0);
               if (sb.size() == 0) begin
                  check("unexpected_done", sb.size(), 1);
               end else begin
                  e = sb.pop_front();
                  check("found", found, e.found);
                  check("sensor_threshold", sensor_threshold, e.thr);
                  check("model_temp", model_temp, e.model);
                  check("latency_edges", cyc - e.start_cyc + 1, e.edges);
                  check("busy_cycles", busy_cnt, e.busy_cycles);
               end
               last_found = found;
               last_thr   = sensor_threshold;
               last_model = model_temp;
               busy_cnt   = 0;
            end
         end
      end
   end

   task automatic run(input logic [4:0] b, input logic [3:0] c, input logic [7:0] t,
                      input logic e_found, input logic [3:0] e_thr, input logic [7:0] e_model,
                      input bit disturb);
      exp_t e;
      bit   got;
      @(negedge clk);
      base   = b;
      coef   = c;
      target = t;
      start  = 1'b1;
      @(posedge clk);
      #1;
      e.found       = e_found;
      e.thr         = e_thr;
      e.model       = e_model;
      e.edges       = e_found ? int'(e_thr) + 2 : 17;
      e.busy_cycles = e_found ? int'(e_thr) + 1 : 16;
      e.start_cyc   = cyc;
      sb.push_back(e);
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            break;
         end
         start = disturb;
         if (disturb) begin
            base   = 5'($urandom_range(0, 31));
            coef   = 4'($urandom_range(0, 15));
            target = 8'($urandom_range(0, 255));
         end
      end
      check("done_seen", got, 1);
      // With disturb, start stays high through the DONE cycle and must be ignored.
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      exp_t g;
      logic [4:0] rb;
      logic [3:0] rc;
      logic [7:0] rt;

      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_found", found, 0);
      check("rst_threshold", sensor_threshold, 0);
      check("rst_model", model_temp, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      run(5'd20, 4'd8,  8'd25, 1'b1, 4'd5,  8'd25, 1'b0);
      run(5'd0,  4'd3,  8'd5,  1'b1, 4'd14, 8'd5,  1'b0);
      run(5'd31, 4'd15, 8'd60, 1'b0, 4'd15, 8'd59, 1'b0);
      run(5'd10, 4'd4,  8'd0,  1'b1, 4'd0,  8'd10, 1'b0);
      run(5'd25, 4'd0,  8'd25, 1'b1, 4'd0,  8'd25, 1'b0);

      // Abort a search with reset in its fourth SEARCH cycle.
      @(negedge clk);
      base   = 5'd0;
      coef   = 4'd1;
      target = 8'd2;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("pre_abort_busy", busy, 1);
      rst = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_found", found, 0);
      check("abort_threshold", sensor_threshold, 0);
      check("abort_model", model_temp, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      run(5'd20, 4'd0, 8'd21, 1'b0, 4'd15, 8'd20, 1'b0);
      run(5'd0,  4'd8, 8'd7,  1'b1, 4'd7,  8'd7,  1'b1);
      run(5'd3,  4'd5, 8'd12, 1'b1, 4'd15, 8'd12, 1'b1);

      for (int i = 0; i < 40; i++) begin
         rb = 5'($urandom_range(0, 31));
         rc = 4'($urandom_range(0, 15));
         rt = 8'($urandom_range(0, 63));
         g  = golden(rb, rc, rt);
         run(rb, rc, rt, g.found, g.thr, g.model, (i % 4) == 0);
      end

      repeat (4) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
